// File: rtl/fb_arbiter.sv
`timescale 1ns/1ps
// fb_arbiter: shares one single-port framebuffer RAM between the display
// fetcher (read, priority) and the host writer (bounded wait), and swaps the
// front/back banks only on a frame boundary.
module fb_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 24,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic              clk_25MHz,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  input  logic              swap_req,
  input  logic              frame_end,
  output logic              swap_done,
  output logic              front,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  typedef enum logic {
    S_IDLE,
    S_PENDING
  } swap_state_e;

  swap_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              front_q, front_d;
  logic              swap_done_q, swap_done_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rvalid_q, rvalid_d;
  logic              starve;

  // Combinational arbitration: display wins unless the host has starved.
  always_comb begin
    starve   = (wait_cnt_q >= WAIT_MAX);
    host_gnt = !rst && host_req && (!disp_req || starve);
    disp_gnt = !rst && disp_req && !host_gnt;
  end

  // Next-state for the wait counter, RAM command, read pipeline and swap FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    wait_cnt_d  = '0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd_pend_d   = disp_gnt;
    rvalid_d    = rd_pend_q;
    state_d     = state_q;
    front_d     = front_q;
    swap_done_d = 1'b0;

    if (host_req && !host_gnt) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end

    // Bank is taken from the current front; a toggle this cycle only affects later grants.
    if (disp_gnt) begin
      ram_en_d   = 1'b1;
      ram_addr_d = {front_q, disp_addr};
    end else if (host_gnt) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = {~front_q, host_addr};
      ram_wdata_d = host_wdata;
    end

    unique case (state_q)
      S_IDLE: begin
        if (swap_req && frame_end) begin
          front_d     = ~front_q;
          swap_done_d = 1'b1;
        end else if (swap_req) begin
          state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        // Extra swap_req pulses are ignored here so a frame never swaps twice.
        if (frame_end) begin
          front_d     = ~front_q;
          swap_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops in-flight reads and pending swaps.
  always_ff @(posedge clk_25MHz) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      front_q     <= front_d;
      swap_done_q <= swap_done_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_pend_q   <= rd_pend_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign front       = front_q;
  assign swap_done   = swap_done_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign disp_rvalid = rvalid_q;
  assign disp_rdata  = ram_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for fb_arbiter: stimulus pushes expected RAM commands and
// read data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_fb_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 24;

  typedef struct packed {
    logic              we;
    logic [ADDR_W:0]   addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic              clk_25MHz = 1'b0;
  logic              rst;
  logic              disp_req, host_req, swap_req, frame_end;
  logic [ADDR_W-1:0] disp_addr, host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              disp_gnt, host_gnt, disp_rvalid, swap_done, front;
  logic [DATA_W-1:0] disp_rdata, ram_wdata, ram_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W:0]   ram_addr;

  logic [DATA_W-1:0] mem [0:(1<<(ADDR_W+1))-1];

  cmd_t              cmd_q [$];
  logic [DATA_W-1:0] rd_q  [$];
  int                n_checks = 0;
  int                n_fail   = 0;

  fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_MAX_WAIT(8)) dut (
    .clk_25MHz(clk_25MHz), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt),
    .swap_req(swap_req), .frame_end(frame_end), .swap_done(swap_done), .front(front),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Single-port RAM model with one-cycle read latency; bank0 = C00000|a, bank1 = C00400|a.
  initial begin
    for (int i = 0; i < (1 << (ADDR_W + 1)); i++) mem[i] = 24'hC00000 | 24'(i);
  end
  always @(posedge clk_25MHz) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [ADDR_W:0] addr, input logic [DATA_W-1:0] wd);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wd;
    cmd_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_ram_en",    ram_en,      0);
    check("rst_ram_we",    ram_we,      0);
    check("rst_ram_addr",  ram_addr,    0);
    check("rst_ram_wdata", ram_wdata,   0);
    check("rst_rvalid",    disp_rvalid, 0);
    check("rst_swap_done", swap_done,   0);
    check("rst_front",     front,       0);
  endtask

  // Monitor: compare every RAM command and every read beat against the queues.
  always @(negedge clk_25MHz) begin : monitor
    cmd_t              e;
    logic [DATA_W-1:0] d;
    if (ram_en) begin
      if (cmd_q.size() == 0) check("cmd_unexpected", ram_en, 0);
      else begin
        e = cmd_q.pop_front();
        check("cmd_we",   ram_we,   e.we);
        check("cmd_addr", ram_addr, e.addr);
        if (e.we) check("cmd_wdata", ram_wdata, e.wdata);
      end
    end else begin
      check("idle_we", ram_we, 0);
    end
    if (disp_rvalid) begin
      if (rd_q.size() == 0) check("rd_unexpected", disp_rvalid, 0);
      else begin
        d = rd_q.pop_front();
        check("rd_data", disp_rdata, d);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; disp_req = 1'b1; host_req = 1'b1; swap_req = 1'b0; frame_end = 1'b0;
    disp_addr = '0; host_addr = '0; host_wdata = '0;
    repeat (2) tick();
    @(negedge clk_25MHz);
    check("rst_disp_gnt", disp_gnt, 0);
    check("rst_host_gnt", host_gnt, 0);
    check_reset_vals();
    tick();
    rst = 1'b0; disp_req = 1'b0; host_req = 1'b0;

    // Display only: addresses 0..3 from bank 0, back to back.
    for (int i = 0; i < 4; i++) begin
      disp_req = 1'b1; disp_addr = 10'(i);
      @(negedge clk_25MHz);
      check("d_only_disp_gnt", disp_gnt, 1);
      check("d_only_host_gnt", host_gnt, 0);
      push_cmd(1'b0, {1'b0, 10'(i)}, '0);
      rd_q.push_back(24'hC00000 | 24'(i));
      tick();
    end
    disp_req = 1'b0;
    repeat (3) tick();

    // Host only: write addr 5 into the back bank (bank 1).
    host_req = 1'b1; host_addr = 10'd5; host_wdata = 24'hABCDEF;
    @(negedge clk_25MHz);
    check("h_only_host_gnt", host_gnt, 1);
    check("h_only_disp_gnt", disp_gnt, 0);
    push_cmd(1'b1, 11'h405, 24'hABCDEF);
    tick();
    host_req = 1'b0;
    repeat (2) tick();

    // Continuous contention: host wins after 8 denied cycles (cycles 8 and 17).
    for (int k = 0; k < 18; k++) begin
      logic h_exp;
      h_exp = (k == 8) || (k == 17);
      disp_req = 1'b1; host_req = 1'b1;
      disp_addr = 10'(k); host_addr = 10'(k); host_wdata = 24'h100000 | 24'(k);
      @(negedge clk_25MHz);
      check("cont_host_gnt", host_gnt, h_exp);
      check("cont_disp_gnt", disp_gnt, !h_exp);
      if (h_exp) push_cmd(1'b1, {1'b1, 10'(k)}, 24'h100000 | 24'(k));
      else begin
        push_cmd(1'b0, {1'b0, 10'(k)}, '0);
        rd_q.push_back(24'hC00000 | 24'(k));
      end
      tick();
    end
    disp_req = 1'b0; host_req = 1'b0;
    repeat (3) tick();

    // Swap sequencing: lone frame_end at 5, swap_req at 10 and 20, frame_end at 50.
    for (int c = 0; c < 60; c++) begin
      swap_req  = (c == 10) || (c == 20);
      frame_end = (c == 5) || (c == 50);
      @(negedge clk_25MHz);
      check("swap_done_seq", swap_done, (c == 51));
      check("front_seq",     front,     (c >= 51));
      tick();
    end
    swap_req = 1'b0; frame_end = 1'b0;

    // After the swap: reads from bank 1, writes to bank 0.
    disp_req = 1'b1; disp_addr = 10'd5;
    @(negedge clk_25MHz);
    check("post_swap_disp_gnt", disp_gnt, 1);
    push_cmd(1'b0, 11'h405, '0);
    rd_q.push_back(24'hABCDEF);
    tick();
    disp_addr = 10'd8;
    @(negedge clk_25MHz);
    push_cmd(1'b0, 11'h408, '0);
    rd_q.push_back(24'h100008);
    tick();
    disp_req = 1'b0; host_req = 1'b1; host_addr = 10'd3; host_wdata = 24'h123456;
    @(negedge clk_25MHz);
    check("post_swap_host_gnt", host_gnt, 1);
    push_cmd(1'b1, 11'h003, 24'h123456);
    tick();
    host_req = 1'b0;
    repeat (3) tick();

    // Same-cycle swap_req + frame_end swaps immediately; a lone frame_end does nothing.
    swap_req = 1'b1; frame_end = 1'b1;
    @(negedge clk_25MHz);
    check("imm_front_before", front, 1);
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
    @(negedge clk_25MHz);
    check("imm_swap_done", swap_done, 1);
    check("imm_front",     front,     0);
    tick();
    frame_end = 1'b1;
    @(negedge clk_25MHz);
    check("imm_done_once", swap_done, 0);
    tick();
    frame_end = 1'b0;
    @(negedge clk_25MHz);
    check("lone_fe_front", front,     0);
    check("lone_fe_done",  swap_done, 0);
    tick();

    // Reset mid-operation: pending swap and in-flight read are dropped.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0; disp_req = 1'b1; disp_addr = 10'd7;
    @(negedge clk_25MHz);
    check("pre_rst_disp_gnt", disp_gnt, 1);
    push_cmd(1'b0, 11'h007, '0);
    tick();
    rst = 1'b1; disp_addr = 10'd1;
    @(negedge clk_25MHz);
    check("mid_rst_disp_gnt", disp_gnt, 0);
    check("mid_rst_host_gnt", host_gnt, 0);
    tick();
    rst = 1'b0; disp_req = 1'b0;
    @(negedge clk_25MHz);
    check_reset_vals();
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    @(negedge clk_25MHz);
    check("rst_drop_swap_front", front,     0);
    check("rst_drop_swap_done",  swap_done, 0);
    repeat (3) tick();
    @(negedge clk_25MHz);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("rd_q_drained",  rd_q.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Shares the single-port framebuffer RAM between the display line fetcher and the host pixel writer, and manages front/back buffer swapping. Display reads always target the front bank; host writes always target the back bank. The display has priority, with a bounded-wait guarantee for the host. Bank swaps happen only on a frame boundary reported by the matrix controller, so a frame is never displayed half-updated.

## Interface

Parameters:
- ADDR_W, 10, word address width within one bank
- DATA_W, 24, RAM word width
- HOST_MAX_WAIT, 8, consecutive denied cycles after which the host wins arbitration (≥1)

Ports:
- clk_25MHz  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- disp_req  in  1  display read request; held until granted
- disp_addr  in  ADDR_W  display word address
- disp_gnt  out  1  display request accepted this cycle
- disp_rdata  out  DATA_W  read data, equal to ram_rdata
- disp_rvalid  out  1  disp_rdata valid this cycle
- host_req  in  1  host write request; held until granted
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host write accepted this cycle
- swap_req  in  1  one-cycle pulse requesting a buffer swap
- frame_end  in  1  one-cycle pulse from the matrix controller at row wrap
- swap_done  out  1  one-cycle pulse when the swap takes effect
- front  out  1  current front bank
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W+1  {bank, word address}
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; one-cycle latency after the ram_en cycle

## Operation

- Arbitration is combinational in cycle N, with at most one grant per cycle:
  - host_gnt = host_req && (!disp_req || starve)
  - disp_gnt = disp_req && !host_gnt
- starve is high when wait_cnt ≥ HOST_MAX_WAIT.
- wait_cnt (width clog2(HOST_MAX_WAIT+1)):
  - increments, saturating, in each cycle where host_req && !host_gnt
  - clears on host_gnt or when host_req is low
- A granted display access registers ram_en=1, ram_we=0, ram_addr={front, disp_addr}.
- A granted host access registers ram_en=1, ram_we=1, ram_addr={~front, host_addr}, ram_wdata=host_wdata.
- In a cycle with no grant, ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their previous values.
- Swap FSM:
  - S_IDLE: on swap_req go to S_PENDING. If frame_end arrives in the same cycle, swap immediately (see below) and stay in S_IDLE.
  - S_PENDING: on frame_end, toggle front, pulse swap_done next cycle, return to S_IDLE. Further swap_req pulses here are ignored, so no double swap occurs.
  - frame_end in S_IDLE without swap_req has no effect.
- The bank used for an access is the value of front in its grant cycle. A toggle in that same cycle affects only later grants.
- Host writes are never blocked by a pending swap. The host must stop writing after swap_req until swap_done if it needs frame coherency.

## Timing

- Grant to RAM command: the command is visible in cycle N+1.
- Read data: ram_rdata is valid in cycle N+2. disp_rvalid is a registered copy of the display-grant pipeline and is high in cycle N+2. Reads are fully pipelined, one per cycle.
- Back-to-back grants are allowed every cycle; the RAM command changes every cycle.
- swap_done is high in the cycle after the frame_end that causes the toggle. front shows the new value in that same cycle.
- Reset values:
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0
  - disp_rvalid=0, swap_done=0, front=0
  - wait_cnt=0, FSM=S_IDLE
  - disp_gnt=0 and host_gnt=0 while rst is high
- Reset mid-operation drops the in-flight read: disp_rvalid=0 in the cycle after reset is sampled. A pending swap is discarded.
- HOST_MAX_WAIT=1: the host wins after one denied cycle, so the two requesters alternate under continuous contention.

## Test plan

- Display only, disp_req held high with addresses 0..3 → ram_addr=0x000..0x003 in cycles 1..4 and disp_rvalid high in cycles 2..5, with disp_rdata matching the RAM model.
- Host only, writing addr 5, data 0xABCDEF, after reset → ram_en=1, ram_we=1, ram_addr=0x405 (bank 1), ram_wdata=0xABCDEF one cycle after the grant.
- Continuous contention with HOST_MAX_WAIT=8 → host_gnt once every 9 cycles, disp_gnt in the other 8, and no cycle with both grants.
- Swap sequencing:
  - swap_req at cycle 10, frame_end at cycle 50 → front toggles to 1 and swap_done pulses at cycle 51.
  - A second swap_req at cycle 20 is ignored.
  - Afterwards, display reads hit bank 1 and host writes hit bank 0.
- swap_req and frame_end in the same cycle → immediate swap, swap_done the next cycle. frame_end alone → no toggle.
- rst asserted in the grant cycle of a display read → no disp_rvalid afterwards, all outputs at reset values, front=0.
